// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit device-clocked frame, ACK check, timeout.
// Latency: accept to start bit is C_inhibit_cycles cycles; each bit follows a device clock fall by sync+filter+1 cycles.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while busy; done pulses once per transaction.
module ps2_host_tx #(
    parameter int C_filter         = 4,
    parameter int C_inhibit_cycles = 2500,
    parameter int C_timeout_cycles = 375000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       error,
    output logic       busy,
    input  logic       ps2clk_in,
    output logic       ps2clk_oe,
    input  logic       ps2dat_in,
    output logic       ps2dat_oe
);

    localparam int FW = $clog2(C_filter + 1);
    localparam int IW = $clog2(C_inhibit_cycles + 1);
    localparam int TW = $clog2(C_timeout_cycles + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(C_filter - 1);
    localparam logic [IW-1:0] INH_LAST  = IW'(C_inhibit_cycles - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(C_timeout_cycles - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    bit_k;
    logic [9:0]    shreg;     // {stop, parity, D7..D0}, shifted out LSB first
    logic          drv_low;   // current frame bit is 0, so pull the data line low
    logic          err_q;

    logic          inh_last;
    logic          timing_active;
    logic          timeout_hit;

    // Two-flop synchronizers for both pads; idle bus level is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2clk_in};
            dat_sync <= {dat_sync[0], ps2dat_in};
        end
    end

    // Clock deglitch: the filtered clock follows only after C_filter consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync[1] != clk_filt) begin
            if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Fall is flagged in the cycle whose edge moves the filtered clock from 1 to 0.
    assign fall = clk_filt & ~clk_sync[1] & (filt_cnt == FILT_LAST);

    assign inh_last      = (state == S_INHIBIT) && (inh_cnt == INH_LAST);
    assign timing_active = (state == S_RTS) || (state == S_SHIFT) ||
                           (state == S_ACK) || (state == S_WAIT_IDLE);
    assign timeout_hit   = timing_active && (to_cnt == TO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; the transaction timeout overrides every bus-phase transition.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (tx_valid) state_nx = S_INHIBIT;
            S_INHIBIT:   if (inh_last) state_nx = S_RTS;
            S_RTS:       state_nx = S_SHIFT;
            S_SHIFT:     if (fall && (bit_k == 4'd10)) state_nx = S_ACK;
            S_ACK:       if (fall) state_nx = S_WAIT_IDLE;
            S_WAIT_IDLE: if (clk_filt && dat_sync[1]) state_nx = S_DONE;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_nx = S_DONE;
        end
    end

    // Outputs decoded from state; the start bit appears in the last inhibit cycle so the
    // data line is already low before the clock is released.
    always_comb begin
        tx_ready  = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        error     = (state == S_DONE) && err_q;
        ps2clk_oe = (state == S_INHIBIT);
        ps2dat_oe = inh_last || (timing_active && drv_low);
    end

    // Inhibit-length counter, running only while the clock is held low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inh_cnt <= '0;
        end else if (state == S_INHIBIT) begin
            inh_cnt <= inh_cnt + 1'b1;
        end else begin
            inh_cnt <= '0;
        end
    end

    // Transaction timeout counter, measured from RTS entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (timing_active) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    // Frame datapath: latch the byte on accept, shift one bit per device clock fall, capture ACK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_k   <= '0;
            drv_low <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg   <= {1'b1, ~^tx_data, tx_data};
                        bit_k   <= '0;
                        drv_low <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (inh_last) begin
                        drv_low <= 1'b1;
                    end
                end
                S_RTS: begin
                    bit_k <= 4'd1;
                end
                S_SHIFT: begin
                    if (fall) begin
                        drv_low <= ~shreg[0];
                        shreg   <= {1'b0, shreg[9:1]};
                        bit_k   <= bit_k + 4'd1;
                    end
                end
                S_ACK: begin
                    if (fall) begin
                        err_q <= dat_sync[1];
                    end
                end
                default: begin
                end
            endcase
            if (timeout_hit) begin
                err_q   <= 1'b1;
                drv_low <= 1'b0;
            end
        end
    end

endmodule
